// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind uart_rx: SYNC, LEN, payload[LEN], (CHK) -> buffered valid/ready payload stream.
// Latency: frame_ok and first payload byte one cycle after the final frame byte; errors registered one cycle after cause.
// Backpressure: out_ready stalls the drain; rx bytes arriving during drain are dropped (overrun). Optional CHK: UART_FRAME_CHKSUM_EN.
module uart_rx_frame_ctrl #(
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_byte,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LENGTH  = 2'd1;
`ifdef UART_FRAME_CHKSUM_EN
    localparam logic [1:0] ERR_CHKSUM  = 2'd2;
`endif
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef UART_FRAME_CHKSUM_EN
        S_CHKSUM  = 3'd3,
`endif
        S_DRAIN   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      len;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   rd_idx;
    logic [TW-1:0]   tcnt;
    logic [7:0]      buf_mem [MAX_LEN];
    logic            ok_nxt;
    logic            err_nxt;
    logic [1:0]      code_nxt;
    logic            pay_last;
    logic            drain_last;
    logic            xfer;
    logic            timeout;
    logic            tcnt_run;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]      sum;
    logic [7:0]      chk_res;
`endif

    assign out_valid  = (state == S_DRAIN);
    assign out_data   = out_valid ? buf_mem[rd_idx[AW-1:0]] : 8'h00;
    assign drain_last = (8'(rd_idx) == len - 8'd1);
    assign out_last   = out_valid && drain_last;
    assign xfer       = out_valid && out_ready;
    assign pay_last   = (8'(idx) == len - 8'd1);
    // A byte in the same cycle as the final count always wins over the timeout.
    assign timeout    = !rx_done && (tcnt == T_LAST);
    assign tcnt_run   = (state != S_SYNC) && (state != S_DRAIN);
`ifdef UART_FRAME_CHKSUM_EN
    assign chk_res    = sum + rx_byte;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = 2'd0;
        case (state)
            S_SYNC: begin
                if (rx_done && rx_byte == SYNC_BYTE) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_done) begin
                    if (rx_byte > MAX_LEN_B) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_LENGTH;
                        state_nxt = S_SYNC;
                    end else if (rx_byte == 8'd0) begin
`ifdef UART_FRAME_CHKSUM_EN
                        state_nxt = S_CHKSUM;
`else
                        ok_nxt    = 1'b1;
                        state_nxt = S_SYNC;
`endif
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TIMEOUT;
                    state_nxt = S_SYNC;
                end
            end
            S_PAYLOAD: begin
                if (rx_done) begin
                    if (pay_last) begin
`ifdef UART_FRAME_CHKSUM_EN
                        state_nxt = S_CHKSUM;
`else
                        ok_nxt    = 1'b1;
                        state_nxt = S_DRAIN;
`endif
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TIMEOUT;
                    state_nxt = S_SYNC;
                end
            end
`ifdef UART_FRAME_CHKSUM_EN
            S_CHKSUM: begin
                if (rx_done) begin
                    if (chk_res == 8'd0) begin
                        ok_nxt    = 1'b1;
                        state_nxt = (len != 8'd0) ? S_DRAIN : S_SYNC;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_CHKSUM;
                        state_nxt = S_SYNC;
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TIMEOUT;
                    state_nxt = S_SYNC;
                end
            end
`endif
            S_DRAIN: begin
                if (rx_done) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_OVERRUN;
                end
                if (xfer && drain_last) begin
                    state_nxt = S_SYNC;
                end
            end
            default: begin
                state_nxt = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len       <= 8'd0;
            idx       <= '0;
            rd_idx    <= '0;
            tcnt      <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;

            if (!tcnt_run || rx_done) begin
                tcnt <= '0;
            end else if (tcnt != T_LAST) begin
                tcnt <= tcnt + 1'b1;
            end

            if (state_nxt == S_LEN && state != S_LEN) begin
                idx <= '0;
            end else if (state == S_PAYLOAD && rx_done) begin
                idx <= idx + 1'b1;
            end

            if (state == S_LEN && rx_done) begin
                len <= rx_byte;
            end

            if (state_nxt == S_DRAIN && state != S_DRAIN) begin
                rd_idx <= '0;
            end else if (xfer) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

`ifdef UART_FRAME_CHKSUM_EN
    // Running sum starts at LEN so a correct CHK drives LEN+payload+CHK to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= 8'd0;
        end else if (state == S_LEN && rx_done) begin
            sum <= rx_byte;
        end else if (state == S_PAYLOAD && rx_done) begin
            sum <= sum + rx_byte;
        end
    end
`endif

    // Payload storage has no reset; contents are only read after a full frame write.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && rx_done) begin
            buf_mem[idx[AW-1:0]] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; follows UART_FRAME_CHKSUM_EN for the CHK byte.
module tb_uart_rx_frame_ctrl;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int nchecks = 0;
    int nerrors = 0;
    int cyc = 0;
    int ok_cnt = 0;
    logic [7:0] out_q [$];
    logic       last_q [$];
    int         cyc_q [$];
    logic [1:0] err_q [$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_dat = 8'h00;

    uart_rx_frame_ctrl #(
        .MAX_LEN(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_done(rx_done),
        .rx_byte(rx_byte),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_ready(out_ready),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                nchecks++;
                if (out_valid !== 1'b1 || out_data !== stall_dat) begin
                    nerrors++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, stall_dat);
                end
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
                cyc_q.push_back(cyc);
            end
            if (frame_ok) ok_cnt++;
            if (frame_err) err_q.push_back(err_code);
            stall_q = out_valid && !out_ready;
            stall_dat = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_byte = 8'h00;
    endtask

    // Sends SYNC, LEN, up to three payload bytes and (checksum build only) CHK.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] chk);
        logic [7:0] p [3];
        p[0] = p0; p[1] = p1; p[2] = p2;
        send_byte(8'hA5);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) send_byte(p[i]);
`ifdef UART_FRAME_CHKSUM_EN
        send_byte(chk);
`else
        if (chk == 8'hFF) $display("note: chk byte %h unused", chk);
`endif
    endtask

    task automatic clear_mon();
        out_q.delete();
        last_q.delete();
        cyc_q.delete();
        err_q.delete();
        ok_cnt = 0;
    endtask

    task automatic test_reset();
        nchecks++;
        if ({out_valid, out_last, out_data, frame_ok, frame_err, err_code} !== 13'd0) begin
            nerrors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h ok=%b err=%b code=%0d, required all zero",
                     out_valid, out_last, out_data, frame_ok, frame_err, err_code);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
        clear_mon();
        out_ready = 1'b1;
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 8'h97);
        nchecks++;
        if (frame_ok !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            nerrors++;
            $display("FAIL good_latency: ok=%b v=%b d=%h, required ok=1 v=1 d=11", frame_ok, out_valid, out_data);
        end
        idle(6);
        nchecks++;
        if (out_q.size() != 3 || ok_cnt != 1 || err_q.size() != 0) begin
            nerrors++;
            $display("FAIL good_counts: bytes=%0d ok=%0d errs=%0d, required 3 1 0", out_q.size(), ok_cnt, err_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nchecks++;
                if (out_q[i] !== exp_d[i] || last_q[i] !== exp_l[i]) begin
                    nerrors++;
                    $display("FAIL good_byte%0d: data=%h last=%b, required data=%h last=%b", i, out_q[i], last_q[i], exp_d[i], exp_l[i]);
                end
            end
            nchecks++;
            if (cyc_q[1] - cyc_q[0] != 1 || cyc_q[2] - cyc_q[1] != 1) begin
                nerrors++;
                $display("FAIL good_full_rate: gaps %0d %0d, required 1 1", cyc_q[1] - cyc_q[0], cyc_q[2] - cyc_q[1]);
            end
        end
    endtask

    task automatic test_bad_chksum();
`ifdef UART_FRAME_CHKSUM_EN
        clear_mon();
        out_ready = 1'b1;
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 8'h98);
        nchecks++;
        if (frame_err !== 1'b1 || err_code !== 2'd2 || out_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL bad_chk: err=%b code=%0d v=%b, required err=1 code=2 v=0", frame_err, err_code, out_valid);
        end
        idle(3);
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 8'h97);
        idle(6);
        nchecks++;
        if (out_q.size() != 3 || ok_cnt != 1 || err_q.size() != 1) begin
            nerrors++;
            $display("FAIL bad_chk_recover: bytes=%0d ok=%0d errs=%0d, required 3 1 1", out_q.size(), ok_cnt, err_q.size());
        end
`endif
    endtask

    task automatic test_len_err();
        clear_mon();
        out_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h11);
        nchecks++;
        if (frame_err !== 1'b1 || err_code !== 2'd1) begin
            nerrors++;
            $display("FAIL len_err: err=%b code=%0d, required err=1 code=1", frame_err, err_code);
        end
        send_frame(8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        nchecks++;
        if (frame_ok !== 1'b1 || out_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL len_zero: ok=%b v=%b, required ok=1 v=0", frame_ok, out_valid);
        end
        idle(4);
        nchecks++;
        if (out_q.size() != 0 || ok_cnt != 1 || err_q.size() != 1) begin
            nerrors++;
            $display("FAIL len_zero_counts: bytes=%0d ok=%0d errs=%0d, required 0 1 1", out_q.size(), ok_cnt, err_q.size());
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        out_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TO - 1);
        nchecks++;
        if (frame_err !== 1'b0 || err_q.size() != 0) begin
            nerrors++;
            $display("FAIL timeout_early: err=%b errs=%0d, required 0 0", frame_err, err_q.size());
        end
        idle(1);
        nchecks++;
        if (frame_err !== 1'b1 || err_code !== 2'd0) begin
            nerrors++;
            $display("FAIL timeout_fire: err=%b code=%0d, required err=1 code=0", frame_err, err_code);
        end
        idle(3);
        clear_mon();
        send_byte(8'h5A);
        send_byte(8'h00);
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 8'h97);
        idle(6);
        nchecks++;
        if (out_q.size() != 3 || ok_cnt != 1 || err_q.size() != 0) begin
            nerrors++;
            $display("FAIL timeout_recover: bytes=%0d ok=%0d errs=%0d, required 3 1 0", out_q.size(), ok_cnt, err_q.size());
        end else begin
            nchecks++;
            if (out_q[0] !== 8'h11 || out_q[2] !== 8'h33) begin
                nerrors++;
                $display("FAIL timeout_recover_data: %h..%h, required 11..33", out_q[0], out_q[2]);
            end
        end
    endtask

    task automatic test_timeout_race();
        clear_mon();
        out_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h02);
        idle(TO - 1);
        send_byte(8'h11);
        idle(TO - 1);
        send_byte(8'h22);
`ifdef UART_FRAME_CHKSUM_EN
        idle(TO - 1);
        send_byte(8'hCB);
`endif
        nchecks++;
        if (frame_ok !== 1'b1) begin
            nerrors++;
            $display("FAIL race_ok: ok=%b, required 1", frame_ok);
        end
        idle(4);
        nchecks++;
        if (err_q.size() != 0 || out_q.size() != 2) begin
            nerrors++;
            $display("FAIL race_counts: errs=%0d bytes=%0d, required 0 2", err_q.size(), out_q.size());
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
        clear_mon();
        out_ready = 1'b0;
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 8'h97);
        idle(10);
        send_byte(8'h44);
        nchecks++;
        if (frame_err !== 1'b1 || err_code !== 2'd3 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            nerrors++;
            $display("FAIL overrun: err=%b code=%0d v=%b d=%h, required err=1 code=3 v=1 d=11", frame_err, err_code, out_valid, out_data);
        end
        idle(38);
        out_ready = 1'b1;
        idle(5);
        nchecks++;
        if (out_q.size() != 3 || err_q.size() != 1 || ok_cnt != 1) begin
            nerrors++;
            $display("FAIL overrun_counts: bytes=%0d errs=%0d ok=%0d, required 3 1 1", out_q.size(), err_q.size(), ok_cnt);
        end else begin
            for (int i = 0; i < 3; i++) begin
                nchecks++;
                if (out_q[i] !== exp_d[i] || last_q[i] !== exp_l[i]) begin
                    nerrors++;
                    $display("FAIL overrun_byte%0d: data=%h last=%b, required data=%h last=%b", i, out_q[i], last_q[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        out_ready = 1'b1;
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 8'h97);
        idle(3);
        send_frame(8'd1, 8'h77, 8'h00, 8'h00, 8'h88);
        idle(4);
        nchecks++;
        if (out_q.size() != 4 || ok_cnt != 2 || err_q.size() != 0) begin
            nerrors++;
            $display("FAIL b2b_counts: bytes=%0d ok=%0d errs=%0d, required 4 2 0", out_q.size(), ok_cnt, err_q.size());
        end else begin
            nchecks++;
            if (out_q[3] !== 8'h77 || last_q[3] !== 1'b1) begin
                nerrors++;
                $display("FAIL b2b_second: data=%h last=%b, required 77 1", out_q[3], last_q[3]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        clear_mon();
        out_ready = 1'b0;
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 8'h97);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        reset = 1'b1;
        idle(1);
        nchecks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || frame_ok !== 1'b0) begin
            nerrors++;
            $display("FAIL mid_reset: v=%b d=%h ok=%b, required 0 00 0", out_valid, out_data, frame_ok);
        end
        reset = 1'b0;
        idle(2);
        clear_mon();
        out_ready = 1'b1;
        send_frame(8'd2, 8'h55, 8'h66, 8'h00, 8'h43);
        idle(4);
        nchecks++;
        if (out_q.size() != 2 || ok_cnt != 1) begin
            nerrors++;
            $display("FAIL mid_reset_next: bytes=%0d ok=%0d, required 2 1", out_q.size(), ok_cnt);
        end else begin
            nchecks++;
            if (out_q[0] !== 8'h55 || out_q[1] !== 8'h66 || last_q[1] !== 1'b1) begin
                nerrors++;
                $display("FAIL mid_reset_data: %h %h last=%b, required 55 66 1", out_q[0], out_q[1], last_q[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        out_ready = 1'b0;
        idle(3);
        test_reset();
        reset = 1'b0;
        idle(1);
        test_good_frame();
        test_bad_chksum();
        test_len_err();
        test_timeout();
        test_timeout_race();
        test_overrun();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
